// File: rtl/irig_pkg.sv
// irig_pkg: shared definitions for the IRIG-style pulse-width link.
//   - symbol codes carried on the symbol stream
//   - FSM state encodings (the receiver's debug decoder uses the same values)
//   - minimum slot length
package irig_pkg;

  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_MARK = 2'd2;
  localparam logic [1:0] SYM_RSVD = 2'd3;

  localparam int unsigned MIN_SLOT = 2;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    HIGH = 3'b001,
    LOW  = 3'b011
  } state_e;

endpackage

// File: rtl/irig_symbol_tx_if.sv
// irig_symbol_tx_if: symbol-stream handshake between the timecode formatter
// (master) and the pulse transmitter (slave).
//   sym       : 2-bit symbol code
//   sym_valid : sym is presented
//   sym_ready : transmitter accepts sym this cycle
interface irig_symbol_tx_if;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_ready;

  modport master (output sym, output sym_valid, input sym_ready);
  modport slave  (input sym, input sym_valid, output sym_ready);
endinterface

// File: rtl/irig_len_sel.sv
// irig_len_sel: maps a symbol code and the runtime length words to the
// clamped high width H, the effective slot length S and a reserved-code flag.
// Purely combinational.
//   sym                          : symbol code
//   slot_len/zero_len/one_len/mark_len : runtime lengths in cycles
//   h_len                        : high width, clamped to 1..S-1
//   s_len                        : slot length, at least MIN_SLOT
//   err                          : sym was the reserved code
module irig_len_sel
  import irig_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic [1:0]       sym,
  input  logic [CNT_W-1:0] slot_len,
  input  logic [CNT_W-1:0] zero_len,
  input  logic [CNT_W-1:0] one_len,
  input  logic [CNT_W-1:0] mark_len,
  output logic [CNT_W-1:0] h_len,
  output logic [CNT_W-1:0] s_len,
  output logic             err
);

  localparam logic [CNT_W-1:0] MIN_S = CNT_W'(MIN_SLOT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] raw_len;

  // Select the raw width per symbol, then clamp against the effective slot.
  always_comb begin
    raw_len = mark_len;
    err     = 1'b0;
    if (slot_len < MIN_S) begin
      s_len = MIN_S;
    end else begin
      s_len = slot_len;
    end
    case (sym)
      SYM_ZERO: raw_len = zero_len;
      SYM_ONE:  raw_len = one_len;
      SYM_MARK: raw_len = mark_len;
      SYM_RSVD: begin
        // Reserved code is sent as a marker and flagged.
        raw_len = mark_len;
        err     = 1'b1;
      end
      default: begin
        raw_len = mark_len;
        err     = 1'b1;
      end
    endcase
    // At least one high and one low cycle per slot.
    if (raw_len == '0) begin
      h_len = ONE_C;
    end else if (raw_len > (s_len - ONE_C)) begin
      h_len = s_len - ONE_C;
    end else begin
      h_len = raw_len;
    end
  end

endmodule

// File: rtl/irig_symbol_tx.sv
// irig_symbol_tx: drives gpio_out high for a per-symbol width inside a
// fixed-length slot (IRIG-B style pulse-width coding).
//   clk, hard_rst (sync, active-high), ce (global clock enable)
//   sym_if     : symbol handshake (slave side)
//   slot_len, zero_len, one_len, mark_len : runtime lengths in cycles
//   gpio_out   : pulse output (registered)
//   new_slot   : one-cycle pulse on the first high cycle of each slot
//   underrun   : one-cycle pulse when a slot ends with no symbol waiting
//   sym_err    : one-cycle pulse after a reserved code is accepted
//   slot_count : accepted-symbol count, wraps
//   state      : FSM state for debug
module irig_symbol_tx
  import irig_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic             ce,
  irig_symbol_tx_if.slave  sym_if,
  input  logic [CNT_W-1:0] slot_len,
  input  logic [CNT_W-1:0] zero_len,
  input  logic [CNT_W-1:0] one_len,
  input  logic [CNT_W-1:0] mark_len,
  output logic             gpio_out,
  output logic             new_slot,
  output logic             underrun,
  output logic             sym_err,
  output logic [CNT_W-1:0] slot_count,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             gpio_q, gpio_d;
  logic             new_slot_q, new_slot_d;
  logic             underrun_q, underrun_d;
  logic             sym_err_q, sym_err_d;

  logic [CNT_W-1:0] h_sel, s_sel;
  logic             err_sel;
  logic             ready;
  logic             accept;

  irig_len_sel #(.CNT_W(CNT_W)) u_len_sel (
    .sym      (sym_if.sym),
    .slot_len (slot_len),
    .zero_len (zero_len),
    .one_len  (one_len),
    .mark_len (mark_len),
    .h_len    (h_sel),
    .s_len    (s_sel),
    .err      (err_sel)
  );

  // Ready depends only on registered state, so it never combines with sym_valid.
  assign ready  = (state_q == IDLE) || ((state_q == LOW) && (cnt_q == (s_q - ONE_C)));
  assign accept = ce & sym_if.sym_valid & ready;
  assign sym_if.sym_ready = ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    h_d        = h_q;
    s_d        = s_q;
    count_d    = count_q;
    gpio_d     = gpio_q;
    new_slot_d = new_slot_q;
    underrun_d = underrun_q;
    sym_err_d  = sym_err_q;
    if (ce) begin
      new_slot_d = 1'b0;
      underrun_d = 1'b0;
      sym_err_d  = 1'b0;
      if (accept) begin
        // Accept happens only in IDLE or on the last LOW cycle: start a slot.
        state_d    = HIGH;
        cnt_d      = '0;
        h_d        = h_sel;
        s_d        = s_sel;
        count_d    = count_q + ONE_C;
        gpio_d     = 1'b1;
        new_slot_d = 1'b1;
        sym_err_d  = err_sel;
      end else begin
        case (state_q)
          IDLE: begin
            gpio_d = 1'b0;
          end
          HIGH: begin
            cnt_d = cnt_q + ONE_C;
            if (cnt_q == (h_q - ONE_C)) begin
              state_d = LOW;
              gpio_d  = 1'b0;
            end else begin
              gpio_d  = 1'b1;
            end
          end
          LOW: begin
            gpio_d = 1'b0;
            if (cnt_q == (s_q - ONE_C)) begin
              state_d    = IDLE;
              cnt_d      = '0;
              underrun_d = 1'b1;
            end else begin
              cnt_d      = cnt_q + ONE_C;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            gpio_d  = 1'b0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset overrides the clock enable.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      h_q        <= ONE_C;
      s_q        <= CNT_W'(MIN_SLOT);
      count_q    <= '0;
      gpio_q     <= 1'b0;
      new_slot_q <= 1'b0;
      underrun_q <= 1'b0;
      sym_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      h_q        <= h_d;
      s_q        <= s_d;
      count_q    <= count_d;
      gpio_q     <= gpio_d;
      new_slot_q <= new_slot_d;
      underrun_q <= underrun_d;
      sym_err_q  <= sym_err_d;
    end
  end

  assign gpio_out   = gpio_q;
  assign new_slot   = new_slot_q;
  assign underrun   = underrun_q;
  assign sym_err    = sym_err_q;
  assign slot_count = count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_irig_symbol_tx.sv
// tb_irig_symbol_tx: directed self-checking bench for irig_symbol_tx.
module tb_irig_symbol_tx;

  logic        clk;
  logic        hard_rst;
  logic        ce;
  logic [31:0] slot_len, zero_len, one_len, mark_len;
  logic        gpio_out, new_slot, underrun, sym_err;
  logic [31:0] slot_count;
  logic [2:0]  state;

  irig_symbol_tx_if bus();

  irig_symbol_tx #(.CNT_W(32)) dut (
    .clk        (clk),
    .hard_rst   (hard_rst),
    .ce         (ce),
    .sym_if     (bus.slave),
    .slot_len   (slot_len),
    .zero_len   (zero_len),
    .one_len    (one_len),
    .mark_len   (mark_len),
    .gpio_out   (gpio_out),
    .new_slot   (new_slot),
    .underrun   (underrun),
    .sym_err    (sym_err),
    .slot_count (slot_count),
    .state      (state)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]   sym_queue[$];
  bit           ce_toggle = 1'b0;
  logic [127:0] g_act, ns_act, ur_act, er_act;
  logic [31:0]  cnt_log [0:127];

  // Bits start..start+len-1 set.
  function automatic logic [127:0] pulse_run(input int start, input int len);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[start + i] = 1'b1;
    return v;
  endfunction

  // Drive queued symbols for n edges, logging outputs after each edge.
  task automatic run(input int n);
    g_act = '0; ns_act = '0; ur_act = '0; er_act = '0;
    for (int k = 0; k < n; k++) begin
      ce = ce_toggle ? ((k % 2) == 0) : 1'b1;
      if (sym_queue.size() > 0) begin
        bus.sym_valid = 1'b1;
        bus.sym       = sym_queue[0];
        if (ce && bus.sym_ready) void'(sym_queue.pop_front());
      end else begin
        bus.sym_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      g_act[k]   = gpio_out;
      ns_act[k]  = new_slot;
      ur_act[k]  = underrun;
      er_act[k]  = sym_err;
      cnt_log[k] = slot_count;
    end
    bus.sym_valid = 1'b0;
    ce = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    hard_rst = 1'b1;
    ce = 1'b0;
    bus.sym_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    hard_rst = 1'b0;
    ce = 1'b1;
    ce_toggle = 1'b0;
    sym_queue.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (gpio_out !== 1'b0) begin n_fail++; $display("FAIL reset_gpio got %b want 0", gpio_out); end
    n_checks++; if (bus.sym_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.sym_ready); end
    n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state got %b want 000", state); end
    n_checks++; if (slot_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", slot_count); end
    n_checks++; if ({new_slot, underrun, sym_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {new_slot, underrun, sym_err}); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] eg, ens;
    do_reset();
    slot_len = 32'd10; zero_len = 32'd2; one_len = 32'd5; mark_len = 32'd8;
    sym_queue = '{2'd0, 2'd1, 2'd2};
    run(30);
    eg  = pulse_run(0, 2) | pulse_run(10, 5) | pulse_run(20, 8);
    ens = pulse_run(0, 1) | pulse_run(10, 1) | pulse_run(20, 1);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL b2b_gpio got %h want %h", g_act, eg); end
    n_checks++; if (ns_act !== ens) begin n_fail++; $display("FAIL b2b_new_slot got %h want %h", ns_act, ens); end
    n_checks++; if (ur_act !== 128'd0) begin n_fail++; $display("FAIL b2b_underrun got %h want 0", ur_act); end
    n_checks++; if (slot_count !== 32'd3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", slot_count); end
  endtask

  task automatic test_underrun();
    logic [127:0] eg, eur;
    do_reset();
    slot_len = 32'd10; zero_len = 32'd2; one_len = 32'd5; mark_len = 32'd8;
    sym_queue = '{2'd1};
    run(12);
    eg  = pulse_run(0, 5);
    eur = pulse_run(10, 1);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL ur_gpio got %h want %h", g_act, eg); end
    n_checks++; if (ur_act !== eur) begin n_fail++; $display("FAIL ur_pulse got %h want %h", ur_act, eur); end
    n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL ur_state got %b want 000", state); end
    n_checks++; if (bus.sym_ready !== 1'b1) begin n_fail++; $display("FAIL ur_ready got %b want 1", bus.sym_ready); end
  endtask

  task automatic test_clamp();
    logic [127:0] eg, ens, eur;
    do_reset();
    slot_len = 32'd10; zero_len = 32'd0; one_len = 32'd5; mark_len = 32'd20;
    sym_queue = '{2'd2, 2'd0};
    run(20);
    eg  = pulse_run(0, 9) | pulse_run(10, 1);
    ens = pulse_run(0, 1) | pulse_run(10, 1);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL clamp_gpio got %h want %h", g_act, eg); end
    n_checks++; if (ns_act !== ens) begin n_fail++; $display("FAIL clamp_new_slot got %h want %h", ns_act, ens); end
    do_reset();
    slot_len = 32'd1; zero_len = 32'd2; one_len = 32'd5;
    sym_queue = '{2'd0, 2'd1};
    run(6);
    eg  = pulse_run(0, 1) | pulse_run(2, 1);
    eur = pulse_run(4, 1);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL min_slot_gpio got %h want %h", g_act, eg); end
    n_checks++; if (ur_act !== eur) begin n_fail++; $display("FAIL min_slot_underrun got %h want %h", ur_act, eur); end
  endtask

  task automatic test_reserved();
    logic [127:0] eg, eer;
    do_reset();
    slot_len = 32'd10; zero_len = 32'd2; one_len = 32'd5; mark_len = 32'd8;
    sym_queue = '{2'd3};
    run(11);
    eg  = pulse_run(0, 8);
    eer = pulse_run(0, 1);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL rsvd_gpio got %h want %h", g_act, eg); end
    n_checks++; if (er_act !== eer) begin n_fail++; $display("FAIL rsvd_sym_err got %h want %h", er_act, eer); end
  endtask

  task automatic test_ce_stall();
    logic [127:0] eg, ens, eur;
    do_reset();
    slot_len = 32'd10; zero_len = 32'd2; one_len = 32'd5; mark_len = 32'd8;
    sym_queue = '{2'd1};
    ce_toggle = 1'b1;
    run(24);
    ce_toggle = 1'b0;
    eg  = pulse_run(0, 10);
    ens = pulse_run(0, 2);
    eur = pulse_run(20, 2);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL ce_gpio got %h want %h", g_act, eg); end
    n_checks++; if (ns_act !== ens) begin n_fail++; $display("FAIL ce_new_slot got %h want %h", ns_act, ens); end
    n_checks++; if (ur_act !== eur) begin n_fail++; $display("FAIL ce_underrun got %h want %h", ur_act, eur); end
    n_checks++; if (cnt_log[1] !== 32'd1) begin n_fail++; $display("FAIL ce_count got %0d want 1", cnt_log[1]); end
  endtask

  task automatic test_mid_reset();
    logic [127:0] eg, ens;
    do_reset();
    slot_len = 32'd10; zero_len = 32'd2; one_len = 32'd5; mark_len = 32'd8;
    sym_queue = '{2'd2};
    run(3);
    hard_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (gpio_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gpio got %b want 0", gpio_out); end
    n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL mid_rst_state got %b want 000", state); end
    n_checks++; if (slot_count !== 32'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", slot_count); end
    hard_rst = 1'b0;
    sym_queue = '{2'd0};
    run(10);
    eg  = pulse_run(0, 2);
    ens = pulse_run(0, 1);
    n_checks++; if (g_act !== eg) begin n_fail++; $display("FAIL post_rst_gpio got %h want %h", g_act, eg); end
    n_checks++; if (ns_act !== ens) begin n_fail++; $display("FAIL post_rst_new_slot got %h want %h", ns_act, ens); end
    n_checks++; if (slot_count !== 32'd1) begin n_fail++; $display("FAIL post_rst_count got %0d want 1", slot_count); end
  endtask

  // Test sequence.
  initial begin
    hard_rst = 1'b1;
    ce = 1'b0;
    bus.sym = 2'd0;
    bus.sym_valid = 1'b0;
    slot_len = 32'd10; zero_len = 32'd2; one_len = 32'd5; mark_len = 32'd8;
    test_reset();
    test_back_to_back();
    test_underrun();
    test_clamp();
    test_reserved();
    test_ce_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
